// File: rtl/io_uart_tx.sv
// Z80 I/O-mapped 8N1 serial transmitter: OUT to the data port queues a byte in a FIFO,
// IN from the status port returns {ovf, busy, idle, full}; bytes leave LSB-first on tx.
module io_uart_tx #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned FIFO_AW     = 3,
  parameter logic [7:0]  PORT_DATA   = 8'h10,
  parameter logic [7:0]  PORT_STATUS = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned DW    = $clog2(CLK_DIV);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               wr_sel_q, wr_arm_q, stat_rd_q, ovf_q, tx_q, busy_q;
  logic               wr_sel_s, rd_sel_s, stat_sel_s, push_s, pop_s, wr_en_s;
  logic               full_s, empty_s, div_last_s, tx_d, busy_d;
  logic [7:0]         status_s;

  assign wr_sel_s   = !iorq_n && m1_n && !wr_n && (addr == PORT_DATA);
  assign rd_sel_s   = !iorq_n && m1_n && !rd_n && ((addr == PORT_DATA) || (addr == PORT_STATUS));
  assign stat_sel_s = rd_sel_s && (addr == PORT_STATUS);
  // wr_arm_q stays low through reset so a strobe held across reset release cannot push
  assign push_s     = wr_sel_s && !wr_sel_q && wr_arm_q;
  assign full_s     = (count_q == CNT_FULL);
  assign empty_s    = (count_q == {(FIFO_AW + 1){1'b0}});
  assign wr_en_s    = push_s && (!full_s || pop_s);
  assign div_last_s = (div_q == DIV_LAST);
  assign status_s   = {4'b0000, ovf_q, busy_q, empty_s && (state_q == S_IDLE), full_s};
  assign tx         = tx_q;
  assign busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel_q  <= 1'b0;
      wr_arm_q  <= 1'b0;
      stat_rd_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_sel_q  <= wr_sel_s;
      wr_arm_q  <= !wr_sel_s;
      stat_rd_q <= stat_sel_s;
      if (push_s && full_s && !pop_s) begin
        ovf_q <= 1'b1;
      end else if (stat_rd_q && !rd_sel_s) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_s) wptr_q <= wptr_q + 1'b1;
      if (pop_s)   rptr_q <= rptr_q + 1'b1;
      case ({wr_en_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          div_d   = '0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (div_last_s) begin
          div_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_last_s) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (div_last_s) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = !empty_s || (state_q != S_IDLE);
  end

  always_comb begin
    data_out    = 8'h00;
    data_out_en = rd_sel_s;
    if (rd_sel_s) begin
      if (addr == PORT_STATUS) begin
        data_out = status_s;
      end else begin
        data_out = 8'hFF;
      end
    end else begin
      data_out = 8'h00;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed + randomized bench for io_uart_tx; a line decoder turns tx back into bytes
// which are compared against the queue of bytes the CPU side accepted.
module tb_io_uart_tx;
  localparam int         CLK_DIV = 4;
  localparam logic [7:0] P_DATA  = 8'h10;
  localparam logic [7:0] P_STAT  = 8'h11;

  logic       clk = 1'b0;
  logic       reset, iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] addr, data_in, data_out;
  logic       data_out_en, tx, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int reset_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rx_ok_q[$];
  int         rx_start_q[$];

  logic [7:0] mon_b;
  logic       mon_ok;
  int         mon_s, mon_rc;
  logic [9:0] line_v;
  logic [7:0] ovf_bytes [9];

  io_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(3), .PORT_DATA(P_DATA), .PORT_STATUS(P_STAT)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data_in(data_in), .data_out(data_out), .data_out_en(data_out_en),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) reset_cnt <= reset_cnt + 1;
  end

  // Line decoder: samples each bit mid-cell; frames interrupted by reset are discarded
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        mon_s  = cyc;
        mon_rc = reset_cnt;
        mon_ok = 1'b1;
        mon_b  = 8'h00;
        repeat (CLK_DIV / 2) @(negedge clk);
        if (tx !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (tx !== 1'b1) mon_ok = 1'b0;
        repeat (CLK_DIV / 2) @(negedge clk);
        if (reset_cnt == mon_rc) begin
          rx_q.push_back(mon_b);
          rx_ok_q.push_back(mon_ok);
          rx_start_q.push_back(mon_s);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold,
                          input int gap, output int e);
    addr = a; data_in = d; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    e = cyc + 1;
    repeat (hold) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, input logic m1v, input string tag,
                         input logic [7:0] exp_d, input logic exp_en);
    addr = a; m1_n = m1v; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk({tag, "_en"}, data_out_en, exp_en);
    chk({tag, "_d"}, data_out, exp_d);
    @(negedge clk);
    chk({tag, "_d_held"}, data_out, exp_d);
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
    #1;
    chk({tag, "_en_after"}, data_out_en, 1'b0);
    chk({tag, "_d_after"}, data_out, 8'h00);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      chk($sformatf("%s_frame%0d", tag, i), rx_ok_q[i], 1'b1);
    end
    exp_q.delete(); rx_q.delete(); rx_ok_q.delete(); rx_start_q.delete();
  endtask

  initial begin
    int e, e1, n, hold, gap;
    logic [7:0] b;
    reset = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 8'h00; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_douten", data_out_en, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single OUT 0x55 held 3 clks: exact line timing and busy release
    addr = P_DATA; data_in = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
    e = cyc + 1;
    @(negedge clk); chk("t1_tx_e0", tx, 1'b1);
    @(negedge clk); chk("t1_tx_e1", tx, 1'b1);
    @(negedge clk); chk("t1_fall_cyc", cyc, e + 2);
    iorq_n = 1'b1; wr_n = 1'b1;
    line_v = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      chk($sformatf("t1_line_k%0d", k), tx, line_v[k / CLK_DIV]);
      if (k == 10 * CLK_DIV - 1) chk("t1_busy_last_stop", busy, 1'b1);
      @(negedge clk);
    end
    chk("t1_busy_drop", busy, 1'b0);
    chk("t1_tx_idle", tx, 1'b1);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h55);
    compare_rx("t1");

    // Back-to-back frames with a single idle clk between them
    io_write(P_DATA, 8'hA3, 2, 1, e1); exp_q.push_back(8'hA3);
    io_write(P_DATA, 8'h0F, 2, 1, e);  exp_q.push_back(8'h0F);
    wait_idle("t2");
    chk("t2_nstarts", rx_start_q.size(), 2);
    if (rx_start_q.size() >= 2) begin
      chk("t2_start1", rx_start_q[0], e1 + 2);
      chk("t2_start2", rx_start_q[1], e1 + 2 + 10 * CLK_DIV + 1);
    end
    compare_rx("t2");

    // One frame in flight, then 9 more OUTs: 8 fill the FIFO, the 9th overflows
    io_write(P_DATA, 8'h3C, 1, 1, e); exp_q.push_back(8'h3C);
    for (int i = 0; i < 9; i++) begin
      ovf_bytes[i] = 8'($urandom);
      io_write(P_DATA, ovf_bytes[i], 1, 1, e);
      if (i < 8) exp_q.push_back(ovf_bytes[i]);
    end
    io_read(P_STAT, 1'b1, "t3_stat_ovf", 8'h0D, 1'b1);
    io_read(P_STAT, 1'b1, "t3_stat_clr", 8'h05, 1'b1);
    wait_idle("t3");
    compare_rx("t3");

    // Port reads while idle
    io_read(P_STAT, 1'b1, "t4_stat_idle", 8'h02, 1'b1);
    io_read(P_DATA, 1'b1, "t4_data_port", 8'hFF, 1'b1);
    io_read(8'h12, 1'b1, "t4_other_port", 8'h00, 1'b0);

    // Interrupt acknowledge never pushes or reads
    io_write(P_DATA, 8'h99, 1, 0, e);
    m1_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0; addr = P_DATA; data_in = 8'h77;
    repeat (3) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h99);
    wait_idle("t5a");
    compare_rx("t5a");
    m1_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0; addr = P_DATA;
    repeat (3) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_inta_busy", busy, 1'b0);
    io_read(P_STAT, 1'b0, "t5_inta_rd", 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    compare_rx("t5");

    // Randomized bursts of at most 8 bytes, random strobe widths and gaps
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b    = 8'($urandom);
        hold = $urandom_range(1, 4);
        gap  = $urandom_range(1, 3);
        io_write(P_DATA, b, hold, gap, e);
        exp_q.push_back(b);
      end
      wait_idle($sformatf("rnd%0d", r));
      compare_rx($sformatf("rnd%0d", r));
    end

    // Write strobe held low across reset release must not push
    reset = 1'b1;
    addr = P_DATA; data_in = 8'h5A; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_held_busy", busy, 1'b0);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_after_busy", busy, 1'b0);
    repeat (CLK_DIV * 2) @(negedge clk);
    compare_rx("t7");

    // Reset mid-DATA with 3 bytes queued
    for (int i = 0; i < 4; i++) io_write(P_DATA, 8'(8'hC0 + i), 1, 1, e);
    repeat (4) @(negedge clk);
    chk("t8_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t8_tx", tx, 1'b1);
    chk("t8_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("t8_tx_quiet", tx, 1'b1);
    compare_rx("t8");
    io_read(P_STAT, 1'b1, "t8_stat", 8'h02, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Z80 I/O-mapped serial transmitter; sits directly downstream of the tv80s core on the CPU bus.
- Decodes IN/OUT cycles on two port addresses and buffers bytes written by the CPU in a small FIFO.
- Shifts the buffered bytes out as 8N1 serial frames on `tx`.
- Returns a status byte to the CPU data-input mux on IN cycles.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit; must be >= 2.
- FIFO_AW, 3: log2 of FIFO depth (default depth 8).
- PORT_DATA, 8'h10: I/O address of the data port (write pushes a byte).
- PORT_STATUS, 8'h11: I/O address of the status port (read only).

Ports:
- clk  input  1  system clock, same clock as the CPU core.
- reset  input  1  synchronous, active-high reset.
- iorq_n  input  1  CPU I/O request, active low.
- m1_n  input  1  CPU M1, active low; iorq_n & m1_n both low = interrupt acknowledge, ignored.
- rd_n  input  1  CPU read strobe, active low.
- wr_n  input  1  CPU write strobe, active low.
- addr  input  8  CPU address A[7:0].
- data_in  input  8  CPU data out (tv80s dout).
- data_out  output  8  read data for the CPU di mux.
- data_out_en  output  1  high while this block drives a valid IN response.
- tx  output  1  serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Strobes:
  - wr_sel = !iorq_n & m1_n & !wr_n & addr==PORT_DATA.
  - rd_sel = !iorq_n & m1_n & !rd_n & (addr==PORT_DATA | addr==PORT_STATUS).
  - Both are registered each clk to detect edges, because a CPU I/O cycle holds a strobe for several clocks.
- Push:
  - Exactly one push per OUT cycle, on the first clk where wr_sel=1 and the previous wr_sel=0.
  - The byte pushed is data_in sampled on that edge.
- FIFO:
  - Depth 2^FIFO_AW, with read/write pointers of FIFO_AW bits that wrap naturally, plus a count of FIFO_AW+1 bits.
  - full: count == depth. empty: count == 0.
- Overflow: a push while full with no simultaneous pop is dropped and sets sticky `ovf`.
- Simultaneous push and pop: always accepted, including when full; count unchanged.
- Reads (combinational):
  - data_out_en = rd_sel; data_out = 0 when rd_sel=0.
  - Status port returns {4'b0, ovf, busy, empty & !shifting, full}; bit0 = full, bit3 = ovf.
  - Data port returns 8'hFF.
- ovf clear: cleared on the clk after rd_sel falls at the end of a status read, so the value is stable for the whole read.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a divider counter (0..CLK_DIV-1) drive the transitions.
  - IDLE: tx=1. If FIFO non-empty: pop into the shift register, clear the divider, go to START.
  - START: tx=0 for CLK_DIV clks, then DATA with bit=0.
  - DATA: tx=shift[0] for CLK_DIV clks, then shift right. After bit 7 go to STOP, else bit+1.
  - STOP: tx=1 for CLK_DIV clks, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 clk between frames when the FIFO is non-empty.
- Latency: push edge E → byte in FIFO after E → IDLE pops at E+1 → tx falls at E+2.
- Frame length: 10*CLK_DIV clks start to stop end; inter-frame gap 1 clk.
- busy = !empty | (state != IDLE).
- Reset (any time, including mid-frame): on the next edge:
  - state = IDLE, tx = 1;
  - FIFO emptied, pointers 0, ovf = 0;
  - divider and bit counters 0, edge registers 0.
  - Outputs after reset: tx=1, busy=0, data_out=0, data_out_en=0.
  - A write strobe that is still held low across the release of reset does not push; a fresh rising→falling edge is required.
- Interrupt-acknowledge cycles (m1_n low) never push, read, or clear ovf.

Test Plan:
- Reset, CLK_DIV=4; one OUT 0x55 to 0x10 held 3 clks → single push; tx falls 2 clks after the strobe is first sampled low. Line pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 clks. busy drops 1 clk after stop ends.
- OUT 0xA3 then 0x0F back-to-back → two frames, LSB-first bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0. Exactly 1 idle clk between stop and the next start.
- 9 OUTs while the first frame has not popped (depth 8) → status reads 0x0D (full, busy, ovf). 9th byte dropped; the 8 transmitted bytes match. The following status read returns 0x05.
- IN from 0x11 when idle after reset → data_out=0x02, data_out_en=1 only while the read strobe is active. IN from 0x10 → 0xFF. IN from 0x12 → data_out_en=0.
- Interrupt acknowledge (iorq_n=0, m1_n=0, wr_n=0, addr=0x10) → no push, busy stays 0.
- Assert reset mid-DATA of frame 1 with 3 bytes queued → tx=1 and busy=0 next clk; no further frames; status=0x02.
